// File: rtl/reg_skid_buffer.sv
// Elastic two-entry pipeline register (main + skid) with registered ready/valid on
// both sides, so neither handshake has a combinational path through the block.
module reg_skid_buffer #(
  parameter int NUM = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           IN_VALID,
  output logic           IN_READY,
  input  logic [NUM-1:0] IN,
  output logic           OUT_VALID,
  input  logic           OUT_READY,
  output logic [NUM-1:0] OUT,
  output logic [1:0]     LEVEL
);

  // Handshake: a word moves on a side only in a cycle where both valid and ready are
  // high at the rising edge; IN_READY and OUT_VALID come straight from flops.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t         state;
  logic [NUM-1:0] skid;
  logic           in_fire;
  logic           out_fire;

  assign in_fire  = IN_VALID & IN_READY;
  assign out_fire = OUT_VALID & OUT_READY;

  // OUT is the main register itself; LEVEL doubles as the FSM state view.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      OUT       <= '0;
      skid      <= '0;
      OUT_VALID <= 1'b0;
      IN_READY  <= 1'b1;
      LEVEL     <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            OUT       <= IN;
            state     <= BUSY;
            OUT_VALID <= 1'b1;
            IN_READY  <= 1'b1;
            LEVEL     <= 2'd1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            OUT <= IN;
          end else if (in_fire) begin
            skid      <= IN;
            state     <= FULL;
            OUT_VALID <= 1'b1;
            IN_READY  <= 1'b0;
            LEVEL     <= 2'd2;
          end else if (out_fire) begin
            state     <= EMPTY;
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
            LEVEL     <= 2'd0;
          end
        end
        FULL: begin
          // Skid word always drains through main, which keeps order intact.
          if (out_fire) begin
            OUT       <= skid;
            state     <= BUSY;
            OUT_VALID <= 1'b1;
            IN_READY  <= 1'b1;
            LEVEL     <= 2'd1;
          end
        end
        default: begin
          state     <= EMPTY;
          OUT_VALID <= 1'b0;
          IN_READY  <= 1'b1;
          LEVEL     <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_skid_buffer.sv
// Directed vector table for reset/stream/stall/release, then a mid-operation reset
// sequence and a random run checked against a queue model of the buffer.
module tb_reg_skid_buffer;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] din;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] dout;
  logic [1:0]   level;

  int total = 0;
  int bad   = 0;

  reg_skid_buffer #(.NUM(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .IN_VALID (in_valid),
    .IN_READY (in_ready),
    .IN       (din),
    .OUT_VALID(out_valid),
    .OUT_READY(out_ready),
    .OUT      (dout),
    .LEVEL    (level)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         e_ov;
    logic [W-1:0] e_out;
    logic         e_ir;
    logic [1:0]   e_lvl;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic iv, input logic [W-1:0] d,
                         input logic ordy, input logic e_ov, input logic [W-1:0] e_out,
                         input logic e_ir, input logic [1:0] e_lvl);
    vec_t v;
    v.rst = r; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ov = e_ov; v.e_out = e_out; v.e_ir = e_ir; v.e_lvl = e_lvl;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // driver: apply inputs, clock once, sample just after the edge
  task automatic step(input logic r, input logic iv, input logic [W-1:0] d, input logic ordy);
    rst = r; in_valid = iv; din = d; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic [W-1:0] o,
                         input logic ir, input logic [1:0] l);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, ".out"},       {16'd0, dout},      {16'd0, o});
    chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, ir});
    chk({tag, ".level"},     {30'd0, level},     {30'd0, l});
  endtask

  // scoreboard model for the random run
  logic [W-1:0] exp_q[$];

  initial begin
    logic         r_iv, r_or, m_in_fire, m_out_fire;
    logic [W-1:0] r_d, prev_out;
    logic         prev_stall;
    int           cnt;

    rst = 1'b1; in_valid = 1'b0; din = '0; out_ready = 1'b0;

    // reset with a word offered: must be discarded
    add_vec(1, 1, 16'hDEAD, 0, 0, 16'h0000, 1, 0);
    add_vec(1, 1, 16'hDEAD, 1, 0, 16'h0000, 1, 0);
    add_vec(0, 0, 16'hDEAD, 0, 0, 16'h0000, 1, 0);
    // OUT_READY toggling while empty has no effect
    add_vec(0, 0, 16'h1111, 1, 0, 16'h0000, 1, 0);
    add_vec(0, 0, 16'h2222, 0, 0, 16'h0000, 1, 0);
    // back-to-back stream 1..8
    for (int i = 1; i <= 8; i++)
      add_vec(0, 1, W'(i), 1, 1, W'(i), 1, 1);
    add_vec(0, 0, 16'h0000, 1, 0, 16'h0008, 1, 0);
    // stall: 0A then 0B fill both entries, 0C is refused
    add_vec(0, 1, 16'h000A, 0, 1, 16'h000A, 1, 1);
    add_vec(0, 1, 16'h000B, 0, 1, 16'h000A, 0, 2);
    add_vec(0, 1, 16'h000C, 0, 1, 16'h000A, 0, 2);
    add_vec(0, 1, 16'h000C, 0, 1, 16'h000A, 0, 2);
    // release: 0B moves to main, then 0C flows through with no gap
    add_vec(0, 1, 16'h000C, 1, 1, 16'h000B, 1, 1);
    add_vec(0, 1, 16'h000C, 1, 1, 16'h000C, 1, 1);
    add_vec(0, 0, 16'h0000, 1, 0, 16'h000C, 1, 0);
    add_vec(0, 0, 16'h0000, 0, 0, 16'h000C, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      chk_all($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_out, vecs[i].e_ir, vecs[i].e_lvl);
    end

    // mid-operation reset while FULL holding 0A, 0B
    step(0, 1, 16'h000A, 0);
    step(0, 1, 16'h000B, 0);
    chk_all("midrst.full", 1, 16'h000A, 0, 2);
    step(1, 1, 16'h000D, 1);
    chk_all("midrst.rst", 0, 16'h0000, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 16'h0000, 1);
      chk_all($sformatf("midrst.after%0d", i), 0, 16'h0000, 1, 0);
    end

    // random run against the queue model
    step(1, 0, 16'h0000, 0);
    step(0, 0, 16'h0000, 0);
    cnt = 0;
    prev_stall = 1'b0;
    prev_out = '0;
    for (int c = 0; c < 10000; c++) begin
      chk("rnd.level", {30'd0, level}, cnt);
      chk("rnd.out_valid", {31'd0, out_valid}, {31'd0, (cnt > 0)});
      chk("rnd.in_ready", {31'd0, in_ready}, {31'd0, (cnt < 2)});
      if (cnt > 0) chk("rnd.out", {16'd0, dout}, {16'd0, exp_q[0]});
      if (prev_stall) chk("rnd.stable", {16'd0, dout}, {16'd0, prev_out});

      r_iv = ($urandom_range(0, 3) != 0);
      r_or = ($urandom_range(0, 2) != 0);
      r_d  = W'($urandom_range(0, 65535));
      m_in_fire  = r_iv && (cnt < 2);
      m_out_fire = (cnt > 0) && r_or;
      prev_stall = (cnt > 0) && !r_or;
      prev_out   = dout;

      step(0, r_iv, r_d, r_or);

      if (m_out_fire) begin
        void'(exp_q.pop_front());
        cnt--;
      end
      if (m_in_fire) begin
        exp_q.push_back(r_d);
        cnt++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
